// File: rtl/sdram_refresh_sched.sv
// Non-data SDRAM command sequencer: powerup init (PRECHARGE-ALL, N x AUTO-REFRESH, LMR)
// followed by periodic refresh scheduling with JEDEC-style postponement while the datapath is busy.
`timescale 1ns/1ps
module sdram_refresh_sched #(
  parameter int TREF_SIZE        = 16,
  parameter int TIMER_SIZE       = 4,
  parameter int MAX_POSTPONE     = 8,
  parameter int INIT_REFRESH_CNT = 8,
  parameter int MODE_SIZE        = 13
) (
  input  logic                                  HCLK,
  input  logic                                  HRESET,
  input  logic                                  init_start_i,
  input  logic [TREF_SIZE-1:0]                  tref_i,
  input  logic [TIMER_SIZE-1:0]                 trp_i,
  input  logic [TIMER_SIZE-1:0]                 trfc_i,
  input  logic [TIMER_SIZE-1:0]                 tmrd_i,
  input  logic [MODE_SIZE-1:0]                  mode_i,
  input  logic                                  bank_idle_i,
  output logic                                  cmd_req_o,
  output logic [1:0]                            cmd_o,
  input  logic                                  cmd_ack_i,
  output logic [MODE_SIZE-1:0]                  mode_o,
  output logic                                  hold_o,
  output logic                                  init_done_o,
  output logic [$clog2(MAX_POSTPONE+1)-1:0]     pending_o,
  output logic                                  ovf_o
);

  localparam int PEND_W = $clog2(MAX_POSTPONE+1);
  localparam int IR_W   = $clog2(INIT_REFRESH_CNT+1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);
  localparam logic [IR_W-1:0]   IR_MAX   = IR_W'(INIT_REFRESH_CNT);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_PRE = 2'b01;
  localparam logic [1:0] CMD_REF = 2'b10;
  localparam logic [1:0] CMD_LMR = 2'b11;

  typedef enum logic [3:0] {
    S_WAIT_INIT, S_I_PRE, S_I_TRP, S_I_REF, S_I_TRFC, S_I_LMR, S_I_TMRD,
    S_IDLE, S_R_PRE, S_R_TRP, S_R_REF, S_R_TRFC
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [TIMER_SIZE-1:0] r_gap;
  logic [IR_W-1:0]       r_init_refs;
  logic                  r_init_done;
  logic [MODE_SIZE-1:0]  r_mode;
  logic [TREF_SIZE-1:0]  r_tick_cnt;
  logic                  r_tick_armed;
  logic [PEND_W-1:0]     r_pending;
  logic                  r_ovf;
  logic                  w_ack;
  logic                  w_gap_done;
  logic                  w_tick;
  logic                  w_ref_ack;

  assign w_ack      = cmd_req_o & cmd_ack_i;
  assign w_gap_done = (r_gap == '0);
  assign w_ref_ack  = (r_state == S_R_REF) & cmd_ack_i;
  assign w_tick     = r_init_done & (tref_i != '0) & r_tick_armed & (r_tick_cnt == '0);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_WAIT_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_INIT: if (init_start_i) w_next = S_I_PRE;
      S_I_PRE:     if (cmd_ack_i)    w_next = S_I_TRP;
      S_I_TRP:     if (w_gap_done)   w_next = S_I_REF;
      S_I_REF:     if (cmd_ack_i)    w_next = S_I_TRFC;
      S_I_TRFC:    if (w_gap_done)   w_next = (r_init_refs == IR_MAX) ? S_I_LMR : S_I_REF;
      S_I_LMR:     if (cmd_ack_i)    w_next = S_I_TMRD;
      S_I_TMRD:    if (w_gap_done)   w_next = S_IDLE;
      S_IDLE:      if ((r_pending != '0) && bank_idle_i) w_next = S_R_PRE;
      S_R_PRE:     if (cmd_ack_i)    w_next = S_R_TRP;
      S_R_TRP:     if (w_gap_done)   w_next = S_R_REF;
      S_R_REF:     if (cmd_ack_i)    w_next = S_R_TRFC;
      S_R_TRFC:    if (w_gap_done)   w_next = S_IDLE;
      default:                       w_next = S_WAIT_INIT;
    endcase
  end

  always_comb begin
    cmd_req_o = 1'b0;
    cmd_o     = CMD_NOP;
    hold_o    = 1'b1;
    case (r_state)
      S_WAIT_INIT:       hold_o = 1'b0;
      S_I_PRE, S_R_PRE:  begin cmd_req_o = 1'b1; cmd_o = CMD_PRE; end
      S_I_REF, S_R_REF:  begin cmd_req_o = 1'b1; cmd_o = CMD_REF; end
      S_I_LMR:           begin cmd_req_o = 1'b1; cmd_o = CMD_LMR; end
      S_IDLE:            hold_o = (r_pending == PEND_MAX);
      default:           ;
    endcase
  end

  // Gap timer: loaded on the accepting edge, the wait state leaves once it reads zero
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_gap <= '0;
    end else if (w_ack) begin
      case (r_state)
        S_I_PRE, S_R_PRE: r_gap <= trp_i;
        S_I_REF, S_R_REF: r_gap <= trfc_i;
        S_I_LMR:          r_gap <= tmrd_i;
        default:          r_gap <= r_gap;
      endcase
    end else if (!w_gap_done) begin
      r_gap <= r_gap - 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_init_refs <= '0;
      r_init_done <= 1'b0;
      r_mode      <= '0;
    end else begin
      if (r_state == S_WAIT_INIT)
        r_init_refs <= '0;
      else if ((r_state == S_I_REF) && w_ack)
        r_init_refs <= r_init_refs + 1'b1;
      if ((r_state == S_I_TMRD) && (w_next == S_IDLE))
        r_init_done <= 1'b1;
      if ((w_next == S_I_LMR) && (r_state != S_I_LMR))
        r_mode <= mode_i;
    end
  end

  // Interval counter: disarmed by tref_i==0 so a new nonzero interval starts a fresh period
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_tick_cnt   <= '0;
      r_tick_armed <= 1'b0;
    end else if (tref_i == '0) begin
      r_tick_armed <= 1'b0;
    end else if (r_init_done) begin
      if (!r_tick_armed || (r_tick_cnt == '0)) begin
        r_tick_cnt   <= tref_i - 1'b1;
        r_tick_armed <= 1'b1;
      end else begin
        r_tick_cnt <= r_tick_cnt - 1'b1;
      end
    end
  end

  // A tick and a refresh ack in the same cycle cancel, even at saturation
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else if (w_tick && !w_ref_ack) begin
      if (r_pending == PEND_MAX) r_ovf     <= 1'b1;
      else                       r_pending <= r_pending + 1'b1;
    end else if (w_ref_ack && !w_tick) begin
      r_pending <= r_pending - 1'b1;
    end
  end

  assign mode_o      = r_mode;
  assign init_done_o = r_init_done;
  assign pending_o   = r_pending;
  assign ovf_o       = r_ovf;

endmodule
